// File: rtl/lpf_post_decim.sv
// lpf_post_decim: boxcar decimator for the FIR low-pass output stream.
// Sums DECIM = 2^LOG2_DECIM valid samples, rounds (half up) and arithmetically
// shifts the sum by SHIFT, saturates it to 8-bit signed, and reports the
// peak-to-peak amplitude over each window of 2^WIN_LOG2 decimated samples.
// Ports:
//   sclk, rst         clock and asynchronous active-high reset
//   lpf_wave/_v       signed input sample and its qualifier
//   clr               synchronous clear of accumulation and window state
//   dec_wave/_v       decimated 8-bit signed sample and one-cycle strobe
//   sat_flag          set with dec_wave_v when the sample was clipped
//   pk_amp/pk_v       max - min over the last full window and update strobe
module lpf_post_decim #(
    parameter int unsigned IN_W       = 21,
    parameter int unsigned LOG2_DECIM = 3,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned WIN_LOG2   = 8
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] lpf_wave,
    input  logic                   lpf_wave_v,
    input  logic                   clr,
    output logic signed [7:0]      dec_wave,
    output logic                   dec_wave_v,
    output logic                   sat_flag,
    output logic [8:0]             pk_amp,
    output logic                   pk_v
);

    localparam int unsigned ACC_W = IN_W + LOG2_DECIM;
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam int unsigned DECIM = 1 << LOG2_DECIM;

    localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(127);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -EXT_W'(128);

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    sum_r_q, sum_r_d;
    logic [LOG2_DECIM-1:0]      cnt_q, cnt_d;
    logic                       pend_q, pend_d;
    logic signed [7:0]          dec_wave_q, dec_wave_d;
    logic                       dec_wave_v_q, dec_wave_v_d;
    logic                       sat_flag_q, sat_flag_d;
    logic [WIN_LOG2-1:0]        wcnt_q, wcnt_d;
    logic                       in_win_q, in_win_d;
    logic signed [7:0]          run_max_q, run_max_d;
    logic signed [7:0]          run_min_q, run_min_d;
    logic [8:0]                 pk_amp_q, pk_amp_d;
    logic                       pk_v_q, pk_v_d;

    logic signed [ACC_W-1:0]    wave_ext;
    logic signed [EXT_W-1:0]    sum_ext, rnd, shifted;
    logic signed [7:0]          new_max, new_min;

    assign wave_ext = {{LOG2_DECIM{lpf_wave[IN_W-1]}}, lpf_wave};

    // Guard bit keeps the rounding add from overflowing a full-scale sum.
    assign sum_ext = {sum_r_q[ACC_W-1], sum_r_q};
    assign rnd     = sum_ext + HALF;
    assign shifted = rnd >>> SHIFT;

    // Running extremes including the sample currently on dec_wave.
    always_comb begin
        new_max = dec_wave_q;
        new_min = dec_wave_q;
        if (in_win_q) begin
            if (run_max_q > dec_wave_q) new_max = run_max_q;
            if (run_min_q < dec_wave_q) new_min = run_min_q;
        end
    end

    // Stage 1 accumulate, stage 2 round/saturate, then window peak tracking.
    always_comb begin
        acc_d        = acc_q;
        sum_r_d      = sum_r_q;
        cnt_d        = cnt_q;
        pend_d       = 1'b0;
        dec_wave_d   = dec_wave_q;
        dec_wave_v_d = 1'b0;
        sat_flag_d   = 1'b0;
        wcnt_d       = wcnt_q;
        in_win_d     = in_win_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        pk_amp_d     = pk_amp_q;
        pk_v_d       = 1'b0;

        if (clr) begin
            acc_d    = '0;
            cnt_d    = '0;
            wcnt_d   = '0;
            in_win_d = 1'b0;
        end else begin
            if (lpf_wave_v) begin
                if (cnt_q == LOG2_DECIM'(DECIM - 1)) begin
                    sum_r_d = acc_q + wave_ext;
                    acc_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end else begin
                    acc_d = acc_q + wave_ext;
                    cnt_d = cnt_q + LOG2_DECIM'(1);
                end
            end

            if (pend_q) begin
                dec_wave_v_d = 1'b1;
                if (shifted > SAT_MAX) begin
                    dec_wave_d = 8'sd127;
                    sat_flag_d = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    dec_wave_d = -8'sd128;
                    sat_flag_d = 1'b1;
                end else begin
                    dec_wave_d = shifted[7:0];
                end
            end

            if (dec_wave_v_q) begin
                run_max_d = new_max;
                run_min_d = new_min;
                wcnt_d    = wcnt_q + WIN_LOG2'(1);
                if (&wcnt_q) begin
                    pk_amp_d = {new_max[7], new_max} - {new_min[7], new_min};
                    pk_v_d   = 1'b1;
                    in_win_d = 1'b0;
                end else begin
                    in_win_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            sum_r_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            dec_wave_q   <= '0;
            dec_wave_v_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            wcnt_q       <= '0;
            in_win_q     <= 1'b0;
            run_max_q    <= '0;
            run_min_q    <= '0;
            pk_amp_q     <= '0;
            pk_v_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            sum_r_q      <= sum_r_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            dec_wave_q   <= dec_wave_d;
            dec_wave_v_q <= dec_wave_v_d;
            sat_flag_q   <= sat_flag_d;
            wcnt_q       <= wcnt_d;
            in_win_q     <= in_win_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            pk_amp_q     <= pk_amp_d;
            pk_v_q       <= pk_v_d;
        end
    end

    assign dec_wave   = dec_wave_q;
    assign dec_wave_v = dec_wave_v_q;
    assign sat_flag   = sat_flag_q;
    assign pk_amp     = pk_amp_q;
    assign pk_v       = pk_v_q;

endmodule

// File: doc/lpf_post_decim.md
# lpf_post_decim

Post-processing stage directly downstream of the FIR low-pass filter. It consumes the filter's 21-bit signed output stream and valid, and decimates by a power of two using an integrate-and-dump (boxcar) average. It rounds and saturates the result to an 8-bit signed sample, and reports the peak-to-peak amplitude over a window of decimated samples for monitoring and debug capture.

## Interface
Parameters:
- IN_W, 21, input sample width, signed two's complement
- LOG2_DECIM, 3, decimation factor DECIM = 2^LOG2_DECIM (default 8)
- SHIFT, 16, total arithmetic right shift applied to the accumulated sum; must be ≥ 1
- WIN_LOG2, 8, peak window length = 2^WIN_LOG2 decimated samples (default 256)

Ports:
- sclk  in  1  system clock, sole clock domain
- rst  in  1  asynchronous, active-high reset
- lpf_wave  in  IN_W  signed filtered sample from the FIR
- lpf_wave_v  in  1  lpf_wave qualifier; any duty cycle, including every cycle
- clr  in  1  synchronous clear of accumulation and window state
- dec_wave  out  8  signed decimated, rounded and saturated sample
- dec_wave_v  out  1  one-cycle strobe; dec_wave is valid
- sat_flag  out  1  high with dec_wave_v when that sample was clipped
- pk_amp  out  9  unsigned max − min of dec_wave over the last full window
- pk_v  out  1  one-cycle strobe; pk_amp was updated

## Operation
- Accumulator acc is IN_W+LOG2_DECIM bits signed (24 by default), with sample counter cnt of LOG2_DECIM bits.
- On each lpf_wave_v with cnt < DECIM−1: acc += sign-extended lpf_wave, cnt++.
- On lpf_wave_v with cnt = DECIM−1 (the last sample):
  - sum_r <= acc + lpf_wave
  - acc <= 0, cnt <= 0, pend <= 1
  - The next valid sample starts a new block with no gap cycle.
- Stage 2, when pend = 1:
  - r = (sum_r + 2^(SHIFT−1)) >>> SHIFT (round half up, arithmetic shift).
  - Clip r to [−128, 127]. sat_flag = 1 if clipped.
  - Register dec_wave and assert dec_wave_v for one cycle.
  - Rounding add and shift are computed at full width plus 1 guard bit, so no internal overflow.
- Peak tracker, on each dec_wave_v:
  - First sample of a window: run_max = run_min = sample.
  - Other samples: run_max = max(run_max, sample), run_min = min(run_min, sample).
  - Window counter wcnt of WIN_LOG2 bits increments.
  - On the 2^WIN_LOG2-th sample: pk_amp <= run_max − run_min, with the final sample included (9-bit unsigned, range 0..255). pk_v pulses and the window restarts.
- clr has priority over lpf_wave_v in the same cycle. It zeroes acc, cnt, pend, wcnt and the first-sample flag, and suppresses any dec_wave_v or pk_v that would have fired on that edge. dec_wave and pk_amp hold their last values.
- Reset values: all outputs 0; acc, sum_r, cnt, pend, wcnt, run_max, run_min all 0.

## Timing
- Edge E0 samples the DECIM-th valid input. dec_wave_v is high in the cycle following edge E0+1, i.e. latency 2 edges, for exactly one cycle.
- pk_v is high one cycle after the dec_wave_v that completes a window (edge E0+2). pk_amp is stable from then on until the next window completes.
- Throughput: at most one dec_wave_v per DECIM valid inputs. The block never stalls and has no back-pressure.
- rst asserted mid-block discards partial sums and any pending output. The first output after release needs DECIM fresh valid samples.
- cnt wraps naturally at DECIM−1 → 0; wcnt wraps at 2^WIN_LOG2−1 → 0.

## Test plan
- Reset, then 8 valid samples of 8192 on consecutive cycles -> exactly one dec_wave_v, 2 edges after the 8th sample, with dec_wave = 1 and sat_flag = 0.
- Rounding and saturation:
  - 8 × 4096 -> dec_wave = 1 (half rounds up).
  - 8 × −4096 -> 0.
  - 8 × 1048575 -> 127 with sat_flag = 1.
  - 8 × −1048576 -> −128 with sat_flag = 0.
- Gapped input: lpf_wave_v every 3rd cycle, value 16384 -> dec_wave = 2 every 24 cycles. No output between blocks.
- Peak window:
  - Stimulus: blocks alternating 8 × 409600 and 8 × −245760, 256 decimated outputs in total.
  - Required: dec_wave alternates 50 and −30, and a single pk_v arrives one cycle after the 256th dec_wave_v with pk_amp = 80.
- Abort paths:
  - clr pulsed after 5 valid samples, then 8 × 8192 -> one output of 1, with the earlier samples discarded.
  - rst asserted for 1 cycle while pend = 1 -> no dec_wave_v, and all outputs read 0.
- Back-to-back blocks at full rate (lpf_wave_v = 1 continuously, 64 cycles) -> exactly 8 dec_wave_v pulses, spaced 8 cycles apart.
